// File: rtl/reorder_buffer_pkg.sv
// Shared widths, types and helpers for the reorder buffer and its
// rename/issue/CDB interface.
package reorder_buffer_pkg;

    localparam int ROB_SIZE = 16;
    localparam int ROBID_W  = $clog2(ROB_SIZE);
    localparam int REGID_W  = 5;
    localparam int XLEN     = 32;

    typedef logic [ROBID_W-1:0] rob_id_t;
    typedef logic [ROBID_W:0]   rob_cnt_t;
    typedef logic [REGID_W-1:0] reg_id_t;
    typedef logic [XLEN-1:0]    word_t;

    typedef struct packed {
        logic    has_dest;
        reg_id_t rd;
    } dest_t;

    // x0 is hardwired, so a retire into it must not raise a register write.
    function automatic logic writes_reg(input dest_t d);
        return d.has_dest && (d.rd != '0);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Bundle of issue, operand lookup, CDB writeback, commit and flush signals
// between the core (master) and the reorder buffer (slave).
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic    IS_sgn;
    reg_id_t IS_rd;
    logic    IS_has_dest;
    logic    ROB_full;
    rob_id_t ROB_name;

    rob_id_t REG_ord1;
    rob_id_t REG_ord2;
    logic    ROB_rdy1;
    logic    ROB_rdy2;
    word_t   ROB_val1;
    word_t   ROB_val2;

    logic    CDB_sgn;
    rob_id_t CDB_name;
    word_t   CDB_val;
    logic    CDB_mispred;
    word_t   CDB_pc;

    logic    ROB_commit_sgn;
    reg_id_t ROB_commit_dest;
    word_t   ROB_commit_value;
    rob_id_t ROB_commit_ROB_name;
    logic    flush_sgn;
    word_t   flush_pc;

    modport master (
        output IS_sgn, IS_rd, IS_has_dest, REG_ord1, REG_ord2,
               CDB_sgn, CDB_name, CDB_val, CDB_mispred, CDB_pc,
        input  ROB_full, ROB_name, ROB_rdy1, ROB_rdy2, ROB_val1, ROB_val2,
               ROB_commit_sgn, ROB_commit_dest, ROB_commit_value,
               ROB_commit_ROB_name, flush_sgn, flush_pc
    );

    modport slave (
        input  IS_sgn, IS_rd, IS_has_dest, REG_ord1, REG_ord2,
               CDB_sgn, CDB_name, CDB_val, CDB_mispred, CDB_pc,
        output ROB_full, ROB_name, ROB_rdy1, ROB_rdy2, ROB_val1, ROB_val2,
               ROB_commit_sgn, ROB_commit_dest, ROB_commit_value,
               ROB_commit_ROB_name, flush_sgn, flush_pc
    );

endinterface

// File: rtl/reorder_buffer_lookup.sv
// One operand lookup port: selects an entry by tag and lets a same-cycle
// CDB broadcast to that tag bypass the stored value.
module reorder_buffer_lookup
    import reorder_buffer_pkg::*;
(
    input  rob_id_t             ord_i,
    input  logic [ROB_SIZE-1:0] valid_i,
    input  logic [ROB_SIZE-1:0] ready_i,
    input  word_t               value_i [ROB_SIZE],
    input  logic                cdb_sgn_i,
    input  rob_id_t             cdb_name_i,
    input  word_t               cdb_val_i,
    output logic                rdy_o,
    output word_t               val_o
);

    logic hit;

    always_comb begin
        hit   = cdb_sgn_i && (cdb_name_i == ord_i);
        rdy_o = valid_i[ord_i] && (ready_i[ord_i] || hit);
        val_o = '0;
        if (rdy_o) begin
            val_o = hit ? cdb_val_i : value_i[ord_i];
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates rename tags at issue, captures
// CDB results, serves operand lookups and retires one entry per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    reorder_buffer_if.slave   bus
);

    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic [ROB_SIZE-1:0] ready_q, ready_d;
    rob_id_t             head_q, head_d;
    rob_id_t             tail_q, tail_d;
    rob_cnt_t            count_q, count_d;

    dest_t               dest_q    [ROB_SIZE];
    word_t               value_q   [ROB_SIZE];
    logic                mispred_q [ROB_SIZE];
    word_t               pc_q      [ROB_SIZE];

    logic                commit_sgn_q;
    reg_id_t             commit_dest_q;
    word_t               commit_value_q;
    rob_id_t             commit_name_q;
    logic                flush_sgn_q;
    word_t               flush_pc_q;

    logic full, alloc, wb, commit, flush;

    // Full/empty come from count alone; head==tail is ambiguous.
    assign full   = (count_q == rob_cnt_t'(ROB_SIZE));
    assign alloc  = rdy && bus.IS_sgn && !full;
    assign wb     = rdy && bus.CDB_sgn && valid_q[bus.CDB_name];
    assign commit = rdy && !flush_sgn_q && valid_q[head_q] && ready_q[head_q];
    assign flush  = commit && mispred_q[head_q];

    always_comb begin
        valid_d = valid_q;
        ready_d = ready_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + rob_cnt_t'(alloc) - rob_cnt_t'(commit);
        if (wb) begin
            ready_d[bus.CDB_name] = 1'b1;
        end
        if (commit) begin
            valid_d[head_q] = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + rob_id_t'(1);
        end
        if (alloc) begin
            valid_d[tail_q] = 1'b1;
            ready_d[tail_q] = 1'b0;
            tail_d          = tail_q + rob_id_t'(1);
        end
        // A retiring mispredicted branch squashes everything, including this cycle's issue.
        if (flush) begin
            valid_d = '0;
            ready_d = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q        <= '0;
            ready_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            commit_sgn_q   <= 1'b0;
            commit_dest_q  <= '0;
            commit_value_q <= '0;
            commit_name_q  <= '0;
            flush_sgn_q    <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            ready_q      <= ready_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            commit_sgn_q <= commit && writes_reg(dest_q[head_q]);
            flush_sgn_q  <= flush;
            if (commit) begin
                commit_dest_q  <= dest_q[head_q].rd;
                commit_value_q <= value_q[head_q];
                commit_name_q  <= head_q;
            end
            if (flush) begin
                flush_pc_q <= pc_q[head_q];
            end
        end
    end

    // Payload needs no reset: it is only observed behind valid/ready.
    always_ff @(posedge clk) begin
        if (alloc) begin
            dest_q[tail_q] <= '{has_dest: bus.IS_has_dest, rd: bus.IS_rd};
        end
        if (wb) begin
            value_q[bus.CDB_name]   <= bus.CDB_val;
            mispred_q[bus.CDB_name] <= bus.CDB_mispred;
            pc_q[bus.CDB_name]      <= bus.CDB_pc;
        end
    end

    rob_id_t ord_a [2];
    logic    rdy_a [2];
    word_t   val_a [2];

    assign ord_a[0] = bus.REG_ord1;
    assign ord_a[1] = bus.REG_ord2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : lookup_g
            reorder_buffer_lookup u_lookup (
                .ord_i      (ord_a[gi]),
                .valid_i    (valid_q),
                .ready_i    (ready_q),
                .value_i    (value_q),
                .cdb_sgn_i  (bus.CDB_sgn),
                .cdb_name_i (bus.CDB_name),
                .cdb_val_i  (bus.CDB_val),
                .rdy_o      (rdy_a[gi]),
                .val_o      (val_a[gi])
            );
        end
    endgenerate

    assign bus.ROB_rdy1            = rdy_a[0];
    assign bus.ROB_val1            = val_a[0];
    assign bus.ROB_rdy2            = rdy_a[1];
    assign bus.ROB_val2            = val_a[1];
    assign bus.ROB_full            = full;
    assign bus.ROB_name            = tail_q;
    assign bus.ROB_commit_sgn      = commit_sgn_q;
    assign bus.ROB_commit_dest     = commit_dest_q;
    assign bus.ROB_commit_value    = commit_value_q;
    assign bus.ROB_commit_ROB_name = commit_name_q;
    assign bus.flush_sgn           = flush_sgn_q;
    assign bus.flush_pc            = flush_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: fill/full, writeback and commit order,
// lookup bypass, mispredict flush, rdy stall, pointer wrap and async reset.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b0;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic hd);
        bus.IS_sgn      = 1'b1;
        bus.IS_rd       = rd;
        bus.IS_has_dest = hd;
        $display("issue  tag=%0d rd=%0d has_dest=%0d", bus.ROB_name, rd, hd);
        step();
        bus.IS_sgn = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] name, input logic [31:0] val,
                       input logic mis, input logic [31:0] pc);
        bus.CDB_sgn     = 1'b1;
        bus.CDB_name    = name;
        bus.CDB_val     = val;
        bus.CDB_mispred = mis;
        bus.CDB_pc      = pc;
        $display("cdb    tag=%0d val=0x%08h mispred=%0d pc=0x%08h", name, val, mis, pc);
        step();
        bus.CDB_sgn     = 1'b0;
        bus.CDB_mispred = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        $display("reset  pulse");
    endtask

    task automatic chk_commit(input string tag, input logic sgn, input logic [4:0] dest,
                              input logic [31:0] val, input logic [3:0] name);
        chk({tag, "_sgn"},  32'(bus.ROB_commit_sgn),      32'(sgn));
        chk({tag, "_dest"}, 32'(bus.ROB_commit_dest),     32'(dest));
        chk({tag, "_val"},  bus.ROB_commit_value,         val);
        chk({tag, "_name"}, 32'(bus.ROB_commit_ROB_name), 32'(name));
        $display("commit tag=%0d sgn=%0d dest=%0d val=0x%08h",
                 bus.ROB_commit_ROB_name, bus.ROB_commit_sgn,
                 bus.ROB_commit_dest, bus.ROB_commit_value);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IS_sgn = 1'b0;  bus.IS_rd = '0;       bus.IS_has_dest = 1'b0;
        bus.REG_ord1 = '0;  bus.REG_ord2 = '0;
        bus.CDB_sgn = 1'b0; bus.CDB_name = '0;    bus.CDB_val = '0;
        bus.CDB_mispred = 1'b0; bus.CDB_pc = '0;
        rdy = 1'b1;
        #1;
        chk("rst_full",   32'(bus.ROB_full),       32'd0);
        chk("rst_name",   32'(bus.ROB_name),       32'd0);
        chk("rst_csgn",   32'(bus.ROB_commit_sgn), 32'd0);
        chk("rst_cval",   bus.ROB_commit_value,    32'd0);
        chk("rst_fsgn",   32'(bus.flush_sgn),      32'd0);
        chk("rst_fpc",    bus.flush_pc,            32'd0);
        repeat (2) step();
        rst_n = 1'b1;

        // Fill all 16 entries with no writeback, then an ignored 17th issue.
        for (int i = 0; i < 16; i++) begin
            issue(5'(i + 1), 1'b1);
            if (i == 14) chk("fill15_full", 32'(bus.ROB_full), 32'd0);
        end
        chk("fill16_full", 32'(bus.ROB_full), 32'd1);
        chk("fill16_name", 32'(bus.ROB_name), 32'd0);
        issue(5'd20, 1'b1);
        chk("over_full", 32'(bus.ROB_full), 32'd1);
        chk("over_name", 32'(bus.ROB_name), 32'd0);
        chk("full_lkp",  32'(bus.ROB_rdy1), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("async_full", 32'(bus.ROB_full), 32'd0);
        rst_n = 1'b1;

        // Single issue/writeback/commit with the minimum CDB->commit latency.
        issue(5'd5, 1'b1);
        chk("t2_name", 32'(bus.ROB_name), 32'd1);
        cdb(4'd0, 32'hDEAD_BEEF, 1'b0, 32'd0);
        chk("t2_early_sgn", 32'(bus.ROB_commit_sgn), 32'd0);
        step();
        chk_commit("t2", 1'b1, 5'd5, 32'hDEAD_BEEF, 4'd0);
        step();
        chk("t2_after_sgn", 32'(bus.ROB_commit_sgn), 32'd0);

        // Lookup with and without the CDB bypass.
        pulse_reset();
        for (int i = 0; i < 4; i++) issue(5'(i + 1), 1'b1);
        bus.REG_ord1 = 4'd3;
        bus.REG_ord2 = 4'd3;
        #1;
        chk("lk_nocdb_rdy2", 32'(bus.ROB_rdy2), 32'd0);
        chk("lk_nocdb_val2", bus.ROB_val2,      32'd0);
        bus.CDB_sgn = 1'b1; bus.CDB_name = 4'd2; bus.CDB_val = 32'd9;
        #1;
        chk("lk_othercdb_rdy1", 32'(bus.ROB_rdy1), 32'd0);
        bus.CDB_name = 4'd3; bus.CDB_val = 32'd7;
        #1;
        chk("lk_byp_rdy1", 32'(bus.ROB_rdy1), 32'd1);
        chk("lk_byp_val1", bus.ROB_val1,      32'd7);
        bus.CDB_sgn = 1'b0;
        cdb(4'd3, 32'd7, 1'b0, 32'd0);
        chk("lk_stored_rdy2", 32'(bus.ROB_rdy2), 32'd1);
        chk("lk_stored_val2", bus.ROB_val2,      32'd7);
        bus.REG_ord1 = 4'd5;
        #1;
        chk("lk_invalid_rdy1", 32'(bus.ROB_rdy1), 32'd0);
        chk("lk_order_sgn", 32'(bus.ROB_commit_sgn), 32'd0);

        // Out-of-order writeback, in-order retire one per cycle.
        pulse_reset();
        issue(5'd1, 1'b1);
        issue(5'd2, 1'b1);
        issue(5'd3, 1'b1);
        cdb(4'd2, 32'h22, 1'b0, 32'd0);
        cdb(4'd1, 32'h11, 1'b0, 32'd0);
        chk("ooo_hold_sgn", 32'(bus.ROB_commit_sgn), 32'd0);
        cdb(4'd0, 32'h10, 1'b0, 32'd0);
        chk("ooo_hold2_sgn", 32'(bus.ROB_commit_sgn), 32'd0);
        step();
        chk_commit("ooo0", 1'b1, 5'd1, 32'h10, 4'd0);
        step();
        chk_commit("ooo1", 1'b1, 5'd2, 32'h11, 4'd1);
        step();
        chk_commit("ooo2", 1'b1, 5'd3, 32'h22, 4'd2);
        step();
        chk("ooo_idle_sgn", 32'(bus.ROB_commit_sgn), 32'd0);

        // Mispredicted branch in entry 1 flushes entries 2..4 and a same-cycle issue.
        pulse_reset();
        for (int i = 0; i < 5; i++) issue(5'(i + 1), 1'b1);
        cdb(4'd0, 32'hA, 1'b0, 32'd0);
        cdb(4'd1, 32'hB, 1'b1, 32'h100);
        chk_commit("mp_c0", 1'b1, 5'd1, 32'hA, 4'd0);
        chk("mp_pre_fsgn", 32'(bus.flush_sgn), 32'd0);
        bus.IS_sgn = 1'b1; bus.IS_rd = 5'd9; bus.IS_has_dest = 1'b1;
        step();
        bus.IS_sgn = 1'b0;
        chk("mp_fsgn", 32'(bus.flush_sgn), 32'd1);
        chk("mp_fpc",  bus.flush_pc,       32'h100);
        chk_commit("mp_c1", 1'b1, 5'd2, 32'hB, 4'd1);
        chk("mp_name", 32'(bus.ROB_name), 32'd0);
        bus.REG_ord1 = 4'd2;
        #1;
        chk("mp_lk_rdy1", 32'(bus.ROB_rdy1), 32'd0);
        cdb(4'd2, 32'hC, 1'b0, 32'd0);
        chk("mp_fsgn_drop", 32'(bus.flush_sgn),      32'd0);
        chk("mp_no_commit", 32'(bus.ROB_commit_sgn), 32'd0);
        step();
        chk("mp_no_commit2", 32'(bus.ROB_commit_sgn), 32'd0);
        chk("mp_name2", 32'(bus.ROB_name), 32'd0);
        chk("mp_full",  32'(bus.ROB_full), 32'd0);

        // rd=0 retire: no register write but value still driven.
        issue(5'd0, 1'b1);
        cdb(4'd0, 32'h55, 1'b0, 32'd0);
        step();
        chk_commit("rd0", 1'b0, 5'd0, 32'h55, 4'd0);

        // rdy low stalls commit and issue.
        issue(5'd7, 1'b1);
        cdb(4'd1, 32'h77, 1'b0, 32'd0);
        rdy = 1'b0;
        bus.IS_sgn = 1'b1; bus.IS_rd = 5'd8;
        step();
        bus.IS_sgn = 1'b0;
        chk("stall_sgn",  32'(bus.ROB_commit_sgn), 32'd0);
        chk("stall_name", 32'(bus.ROB_name),       32'd2);
        chk("stall_val",  bus.ROB_commit_value,    32'h55);
        rdy = 1'b1;
        step();
        chk_commit("stall_go", 1'b1, 5'd7, 32'h77, 4'd1);

        // Async reset clears held commit/flush outputs at once.
        rst_n = 1'b0;
        #1;
        chk("rst2_fpc",  bus.flush_pc,         32'd0);
        chk("rst2_cval", bus.ROB_commit_value, 32'd0);
        chk("rst2_name", 32'(bus.ROB_name),    32'd0);
        rst_n = 1'b1;

        // Drain 14 fillers, then tags 14,15,0,1 across the wrap.
        for (int i = 0; i < 14; i++) issue(5'd1, 1'b0);
        for (int i = 0; i < 14; i++) cdb(4'(i), 32'(i), 1'b0, 32'd0);
        repeat (2) step();
        chk("wrap_name_start", 32'(bus.ROB_name), 32'd14);
        chk("wrap_full_start", 32'(bus.ROB_full), 32'd0);
        for (int i = 0; i < 4; i++) issue(5'(10 + i), 1'b1);
        chk("wrap_name_end", 32'(bus.ROB_name), 32'd2);
        cdb(4'd1,  32'h1001, 1'b0, 32'd0);
        cdb(4'd0,  32'h1000, 1'b0, 32'd0);
        cdb(4'd15, 32'h100F, 1'b0, 32'd0);
        chk("wrap_hold_sgn", 32'(bus.ROB_commit_sgn), 32'd0);
        cdb(4'd14, 32'h100E, 1'b0, 32'd0);
        step();
        chk_commit("wrap14", 1'b1, 5'd10, 32'h100E, 4'd14);
        step();
        chk_commit("wrap15", 1'b1, 5'd11, 32'h100F, 4'd15);
        step();
        chk_commit("wrap0",  1'b1, 5'd12, 32'h1000, 4'd0);
        step();
        chk_commit("wrap1",  1'b1, 5'd13, 32'h1001, 4'd1);

        // Mid-run reset while a commit is being shown.
        rst_n = 1'b0;
        #1;
        chk_commit("rst3", 1'b0, 5'd0, 32'd0, 4'd0);
        chk("rst3_name", 32'(bus.ROB_name), 32'd0);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
